// File: rtl/bbox_mem_pkg.sv
// Shared widths and request/response record layouts for the bbox memory responder.
package bbox_mem_pkg;

    localparam int BBOX_ADDR_W    = 12;
    localparam int BBOX_DATA_W    = 256;
    localparam int BBOX_TAG_W     = 4;
    localparam int BBOX_OUT_DEPTH = 2;

    typedef struct packed {
        logic [BBOX_TAG_W-1:0]  tag;
        logic [BBOX_ADDR_W-1:0] addr;
    } bbox_mem_req_t;

    typedef struct packed {
        logic [BBOX_TAG_W-1:0]  tag;
        logic [BBOX_DATA_W-1:0] data;
    } bbox_mem_resp_t;

endpackage

// File: rtl/bbox_mem_if.sv
// Request (FWFT pop side) and response (push side) stream pair between a traversal unit and its memory.
interface bbox_mem_if #(
    parameter int TAG_WIDTH  = bbox_mem_pkg::BBOX_TAG_W,
    parameter int ADDR_WIDTH = bbox_mem_pkg::BBOX_ADDR_W,
    parameter int DATA_WIDTH = bbox_mem_pkg::BBOX_DATA_W
) ();

    logic                            bbox_mem_req_stream_empty_n;
    logic                            bbox_mem_req_stream_read;
    logic [TAG_WIDTH+ADDR_WIDTH-1:0] bbox_mem_req_stream_dout;
    logic                            bbox_mem_resp_stream_full_n;
    logic                            bbox_mem_resp_stream_write;
    logic [TAG_WIDTH+DATA_WIDTH-1:0] bbox_mem_resp_stream_din;

    modport master (
        output bbox_mem_req_stream_empty_n, bbox_mem_req_stream_dout, bbox_mem_resp_stream_full_n,
        input  bbox_mem_req_stream_read, bbox_mem_resp_stream_write, bbox_mem_resp_stream_din
    );

    modport slave (
        input  bbox_mem_req_stream_empty_n, bbox_mem_req_stream_dout, bbox_mem_resp_stream_full_n,
        output bbox_mem_req_stream_read, bbox_mem_resp_stream_write, bbox_mem_resp_stream_din
    );

endinterface

// File: rtl/bbox_mem_resp_fifo.sv
// Small synchronous response FIFO; the head is read straight from the storage registers.
module bbox_mem_resp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8,
    parameter int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [OCC_W-1:0] occ
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage is cleared on reset so the head presented to the sink reads as zero.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (pop) rd_ptr <= nxt(rd_ptr);
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: ;
            endcase
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/bbox_mem_responder.sv
// Bbox SRAM responder: pops {tag,addr}, reads the read-first SRAM, pushes {tag,data} in order.
// Optional BBOX_MEM_PERF_CNT_EN adds saturating request and stall counters.
module bbox_mem_responder
    import bbox_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = BBOX_ADDR_W,
    parameter int DATA_WIDTH = BBOX_DATA_W,
    parameter int TAG_WIDTH  = BBOX_TAG_W,
    parameter int OUT_DEPTH  = BBOX_OUT_DEPTH
) (
    input  logic                  clk,
    input  logic                  srst,
    bbox_mem_if.slave             bus,
    input  logic                  ld_wr,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_din,
    output logic                  busy
`ifdef BBOX_MEM_PERF_CNT_EN
    ,
    output logic [31:0]           perf_req_cnt,
    output logic [31:0]           perf_stall_cnt
`endif
);

    localparam int OCC_W = $clog2(OUT_DEPTH + 1);

    logic [DATA_WIDTH-1:0] sram [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata;
    logic [TAG_WIDTH-1:0]  req_tag, tag_q;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  read, pop, inflight;
    logic [OCC_W-1:0]      occ;
    logic [OCC_W:0]        pending;

    assign {req_tag, req_addr} = bus.bbox_mem_req_stream_dout;

    // Slots already claimed after this cycle's pop; a new read needs one free slot.
    always_comb begin
        pop     = (occ != '0) && bus.bbox_mem_resp_stream_full_n;
        pending = {1'b0, occ} + (OCC_W+1)'(inflight) - (OCC_W+1)'(pop);
        read    = bus.bbox_mem_req_stream_empty_n && !srst && (pending < (OCC_W+1)'(OUT_DEPTH));
    end

    assign bus.bbox_mem_req_stream_read   = read;
    assign bus.bbox_mem_resp_stream_write = pop;

    always_ff @(posedge clk) begin
        if (srst) inflight <= 1'b0;
        else      inflight <= read;
    end

    // Read-first: a same-cycle load to the read address returns the previous contents.
    always_ff @(posedge clk) begin
        if (ld_wr) sram[ld_addr] <= ld_din;
        if (read) begin
            rdata <= sram[req_addr];
            tag_q <= req_tag;
        end
    end

    bbox_mem_resp_fifo #(
        .DEPTH (OUT_DEPTH),
        .WIDTH (TAG_WIDTH + DATA_WIDTH),
        .OCC_W (OCC_W)
    ) u_fifo (
        .clk  (clk),
        .srst (srst),
        .push (inflight),
        .din  ({tag_q, rdata}),
        .pop  (pop),
        .dout (bus.bbox_mem_resp_stream_din),
        .occ  (occ)
    );

    assign busy = inflight || (occ != '0);

`ifdef BBOX_MEM_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (srst) begin
            perf_req_cnt   <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (read && perf_req_cnt != '1) perf_req_cnt <= perf_req_cnt + 32'd1;
            if (bus.bbox_mem_req_stream_empty_n && !read && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bbox_mem_responder.sv
// Directed bench for bbox_mem_responder: reset, latency, streaming, backpressure, read-first, mid-op reset.
module tb_bbox_mem_responder;
    import bbox_mem_pkg::*;

    localparam int AW = BBOX_ADDR_W;
    localparam int DW = BBOX_DATA_W;
    localparam int TW = BBOX_TAG_W;
    localparam int RW = TW + DW;

    logic          clk = 1'b0;
    logic          srst = 1'b1;
    logic          ld_wr = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_din = '0;
    logic          busy;
`ifdef BBOX_MEM_PERF_CNT_EN
    logic [31:0]   perf_req_cnt, perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    bbox_mem_if #(.TAG_WIDTH(TW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    bbox_mem_responder dut (
        .clk     (clk),
        .srst    (srst),
        .bus     (bus),
        .ld_wr   (ld_wr),
        .ld_addr (ld_addr),
        .ld_din  (ld_din),
        .busy    (busy)
`ifdef BBOX_MEM_PERF_CNT_EN
        ,
        .perf_req_cnt   (perf_req_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    // FWFT request source backed by a small table
    bbox_mem_req_t reqs [64];
    logic [5:0]    src_rd = '0;
    logic [5:0]    src_wr = '0;
    logic          src_en = 1'b0;

    assign bus.bbox_mem_req_stream_empty_n = src_en && (src_rd != src_wr);
    assign bus.bbox_mem_req_stream_dout    = reqs[src_rd];

    int cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.bbox_mem_req_stream_read) src_rd <= src_rd + 6'd1;
    end

    int            rd_log [$];
    int            wr_cyc [$];
    logic [RW-1:0] wr_din [$];
    always @(negedge clk) begin
        if (bus.bbox_mem_req_stream_read) rd_log.push_back(cyc);
        if (bus.bbox_mem_resp_stream_write) begin
            wr_cyc.push_back(cyc);
            wr_din.push_back(bus.bbox_mem_resp_stream_din);
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input logic [7:0] b);
        return {(DW/8){b}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input int tag, input int addr);
        reqs[src_wr] = '{tag: TW'(tag), addr: AW'(addr)};
        src_wr = src_wr + 6'd1;
    endtask

    task automatic load(input int addr, input logic [DW-1:0] d);
        ld_wr   = 1'b1;
        ld_addr = AW'(addr);
        ld_din  = d;
        tick();
        ld_wr   = 1'b0;
    endtask

    task automatic clear_logs();
        rd_log.delete();
        wr_cyc.delete();
        wr_din.delete();
    endtask

    initial begin
        bus.bbox_mem_resp_stream_full_n = 1'b1;

        // SRAM contents survive reset, so preload while srst is high
        load(12'h005, pat(8'hA5));
        load(12'h010, pat(8'h11));
        for (int i = 0; i < 16; i++) load(12'h100 + i, pat(8'(8'h20 + i)));

        // 1: reset holds everything idle even with a request waiting
        push_req(3, 12'h005);
        src_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk("rst_read",  bus.bbox_mem_req_stream_read, 0);
            chk("rst_write", bus.bbox_mem_resp_stream_write, 0);
            chk("rst_busy",  busy, 0);
        end
        chk("rst_din", bus.bbox_mem_resp_stream_din, 0);
        @(posedge clk);
        #1 srst = 1'b0;

        // 2: single request, two-cycle latency
        @(negedge clk);
        chk("rel_read", bus.bbox_mem_req_stream_read, 1);
        @(negedge clk);
        chk("lat_n1_write", bus.bbox_mem_resp_stream_write, 0);
        @(negedge clk);
        chk("lat_n2_write", bus.bbox_mem_resp_stream_write, 1);
        chk("lat_n2_din", bus.bbox_mem_resp_stream_din, {TW'(3), pat(8'hA5)});
        tick();

        // 3: streaming at one per cycle
        clear_logs();
        for (int i = 0; i < 16; i++) push_req(i, 12'h100 + i);
        repeat (24) tick();
        chk("str_nrd",    rd_log.size(), 16);
        chk("str_rd_run", rd_log[15] - rd_log[0], 15);
        chk("str_nwr",    wr_cyc.size(), 16);
        chk("str_wr_run", wr_cyc[15] - wr_cyc[0], 15);
        chk("str_lat",    wr_cyc[0] - rd_log[0], 2);
        for (int i = 0; i < wr_din.size(); i++)
            chk($sformatf("str_din%0d", i), wr_din[i], {TW'(i), pat(8'(8'h20 + i))});
`ifdef BBOX_MEM_PERF_CNT_EN
        chk("perf_req",   perf_req_cnt, 17);
        chk("perf_stall", perf_stall_cnt, 0);
`endif

        // 4: backpressure stops issue at two outstanding, then drains in order
        clear_logs();
        bus.bbox_mem_resp_stream_full_n = 1'b0;
        for (int i = 0; i < 16; i++) push_req(i, 12'h100 + i);
        repeat (10) tick();
        chk("bp_nrd",  rd_log.size(), 2);
        chk("bp_nwr",  wr_cyc.size(), 0);
        chk("bp_busy", busy, 1);
        bus.bbox_mem_resp_stream_full_n = 1'b1;
        repeat (30) tick();
        chk("bp_nrd_end", rd_log.size(), 16);
        chk("bp_nwr_end", wr_cyc.size(), 16);
        for (int i = 0; i < wr_din.size(); i++)
            chk($sformatf("bp_din%0d", i), wr_din[i], {TW'(i), pat(8'(8'h20 + i))});

        // 5: load and read of the same address in one cycle returns old data
        clear_logs();
        push_req(5, 12'h010);
        ld_wr   = 1'b1;
        ld_addr = 12'h010;
        ld_din  = pat(8'hFF);
        @(negedge clk);
        chk("col_read", bus.bbox_mem_req_stream_read, 1);
        tick();
        ld_wr = 1'b0;
        push_req(6, 12'h010);
        repeat (6) tick();
        chk("col_nwr", wr_din.size(), 2);
        chk("col_old", wr_din[0], {TW'(5), pat(8'h11)});
        chk("col_new", wr_din[1], {TW'(6), pat(8'hFF)});

        // 6: reset with two responses queued discards them
        clear_logs();
        bus.bbox_mem_resp_stream_full_n = 1'b0;
        push_req(7, 12'h005);
        push_req(8, 12'h010);
        repeat (4) tick();
        chk("mr_nrd",  rd_log.size(), 2);
        chk("mr_busy", busy, 1);
        srst = 1'b1;
        tick();
        srst = 1'b0;
        clear_logs();
        bus.bbox_mem_resp_stream_full_n = 1'b1;
        @(negedge clk);
        chk("mr_busy0",  busy, 0);
        chk("mr_write0", bus.bbox_mem_resp_stream_write, 0);
        chk("mr_din0",   bus.bbox_mem_resp_stream_din, 0);
`ifdef BBOX_MEM_PERF_CNT_EN
        chk("mr_perf_req", perf_req_cnt, 0);
`endif
        repeat (5) tick();
        chk("mr_nwr",   wr_cyc.size(), 0);
        chk("mr_busy1", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
